// File: rtl/pipe_last_rr_merge.sv
// pipe_last_rr_merge: packet-atomic round-robin merge of NUM_CH PipeOutLast sources into one channel-tagged FIFO
module pipe_last_rr_merge #(
    parameter int WIDTH = 32,
    parameter int NUM_CH = 4,
    parameter int DEPTH = 4,
    localparam int CHW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    output logic [NUM_CH-1:0]       in_deq__ENA,
    input  logic [NUM_CH-1:0]       in_deq__RDY,
    input  logic [NUM_CH*WIDTH-1:0] in_first,
    input  logic [NUM_CH-1:0]       in_first__RDY,
    input  logic [NUM_CH-1:0]       in_last,
    input  logic [NUM_CH-1:0]       in_last__RDY,
    input  logic                    out_deq__ENA,
    output logic                    out_deq__RDY,
    output logic [WIDTH-1:0]        out_first,
    output logic                    out_first__RDY,
    output logic                    out_last,
    output logic                    out_last__RDY,
    output logic [CHW-1:0]          out_chan,
    output logic [AW:0]             count
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t            state_q, state_d;
    logic [CHW-1:0]    rr_ptr_q, rr_ptr_d, owner_q, owner_d, grant, idx;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [NUM_CH-1:0] elig;
    logic              any_elig, space, push, pop, grant_last, nonempty;
    logic [CHW+WIDTH:0] mem_q [DEPTH];
    logic [CHW+WIDTH:0] head;
    assign elig = in_deq__RDY & in_first__RDY & in_last__RDY;
    assign space = count_q != (AW+1)'(DEPTH);
    assign nonempty = count_q != '0;
    // Scan downwards so the channel closest to rr_ptr wins the last assignment
    always_comb begin
        grant = owner_q;
        idx = '0;
        any_elig = elig[owner_q];
        if (state_q == IDLE) begin
            any_elig = 1'b0;
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                idx = CHW'((int'(rr_ptr_q) + k) % NUM_CH);
                if (elig[idx]) begin
                    grant = idx;
                    any_elig = 1'b1;
                end
            end
        end
    end
    // Gating with nRST keeps the pop strobes quiet while reset is asserted
    assign push = any_elig & space & nRST;
    assign pop = out_deq__ENA & nonempty;
    assign grant_last = in_last[grant];
    assign in_deq__ENA = push ? (NUM_CH'(1) << grant) : '0;
    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d = owner_q;
        if (push) begin
            state_d = grant_last ? IDLE : LOCKED;
            owner_d = grant_last ? owner_q : grant;
            rr_ptr_d = !grant_last ? rr_ptr_q : (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            owner_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q <= owner_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= {grant, grant_last, in_first[int'(grant)*WIDTH +: WIDTH]};
    end
    assign head = mem_q[rd_ptr_q];
    assign out_deq__RDY = nonempty;
    assign out_first__RDY = nonempty;
    assign out_last__RDY = nonempty;
    assign out_first = nonempty ? head[WIDTH-1:0] : '0;
    assign out_last = nonempty & head[WIDTH];
    assign out_chan = nonempty ? head[CHW+WIDTH:WIDTH+1] : '0;
    assign count = count_q;
endmodule

// File: doc/pipe_last_rr_merge.md
Name: pipe_last_rr_merge

Overview:
- Parametrised N-channel packet merger: pulls beats from NUM_CH upstream PipeOutLast servers and presents one PipeOutLast server downstream.
- Round-robin arbitration is packet-atomic: a granted channel keeps the grant until its last beat, so packets never interleave.
- A DEPTH-entry FIFO decouples arbitration from downstream backpressure.
- Each output beat is tagged with its source channel. Used in front of NOC packetisers that need several producers sharing one link.

Parameters:
WIDTH, 32, data bits per beat.
NUM_CH, 4, number of input channels; range 2..16.
DEPTH, 4, FIFO entries; power of 2, at least 2.
CHW, derived = max(1, clog2(NUM_CH)), channel-tag width. Not overridable.

Ports:
CLK  input  1  clock; all state on rising edge.
nRST  input  1  asynchronous active-low reset.
in_deq__ENA  output  NUM_CH  pop strobe to channel i; one-hot or zero.
in_deq__RDY  input  NUM_CH  channel i can be popped.
in_first  input  NUM_CH*WIDTH  head data; channel i at bits [i*WIDTH +: WIDTH].
in_first__RDY  input  NUM_CH  in_first slice valid.
in_last  input  NUM_CH  head beat ends packet.
in_last__RDY  input  NUM_CH  in_last valid.
out_deq__ENA  input  1  downstream pop.
out_deq__RDY  output  1  FIFO non-empty.
out_first  output  WIDTH  head-beat data.
out_first__RDY  output  1  FIFO non-empty.
out_last  output  1  head beat ends packet.
out_last__RDY  output  1  FIFO non-empty.
out_chan  output  CHW  source channel of head beat.
count  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE, rr_ptr=0, owner=0, FIFO pointers and count=0.
  - Outputs immediately go to: in_deq__ENA=0, all out_*__RDY=0, out_first=0, out_last=0, out_chan=0.
  - Reset mid-packet discards FIFO contents and any lock; no partial flush.
- Eligibility: elig[i] = in_deq__RDY[i] & in_first__RDY[i] & in_last__RDY[i].
- Space: space = (count != DEPTH). A pop in the same cycle does not create space; there is no combinational out_deq__ENA to in_deq__ENA path.
- IDLE state:
  - grant = first i with elig[i], scanning rr_ptr, rr_ptr+1, ... modulo NUM_CH.
  - If any channel is eligible and space=1: in_deq__ENA[grant]=1 and the beat {grant, in_last[grant], data} is pushed.
  - If the pushed beat has last=1: stay IDLE, rr_ptr <= (grant+1) mod NUM_CH.
  - Otherwise: go to LOCKED, owner <= grant.
- LOCKED state:
  - Only the owner may push: in_deq__ENA[owner] = elig[owner] & space.
  - Other channels are ignored regardless of eligibility.
  - When the owner pushes with last=1: go to IDLE, rr_ptr <= (owner+1) mod NUM_CH.
  - An owner stall (elig low) holds LOCKED indefinitely; there is no timeout.
- Single-beat packets (last on first beat) never enter LOCKED.
- At most one push per cycle; in_deq__ENA is combinational from registered state and current inputs.
- Latency: a beat pushed in cycle t appears at the output head in cycle t+1 if the FIFO was empty.
- Output:
  - out_*__RDY = (count != 0).
  - out_first/out_last/out_chan show the read-pointer entry when non-empty, 0 when empty.
  - out_deq__ENA while empty is a protocol error; it is ignored and state is unchanged.
- Simultaneous push and pop (count in 1..DEPTH-1): count unchanged, both pointers advance.
- Pointers are clog2(DEPTH) bits and wrap naturally. Full/empty are decided by count, not by pointer compare.
- FIFO storage is not reset.

Test Plan:
1. Reset abort: nRST low for 1 cycle while LOCKED with count=3 -> same-cycle count=0, out_deq__RDY=0, in_deq__ENA=0; after release state=IDLE, rr_ptr=0.
2. Single packet: ch2 presents 0xA1, 0xA2, 0xA3 (last on 0xA3), downstream always popping -> out_first 0xA1/0xA2/0xA3 on consecutive cycles starting 1 cycle after the first push; out_chan=2; out_last=1 only with 0xA3.
3. Contention: ch0 and ch1 each hold 2-beat packets from cycle 0, rr_ptr=0 -> output order ch0 b0, ch0 b1, ch1 b0, ch1 b1; no interleave.
4. Fairness: all 4 channels continuously offer single-beat packets -> grant sequence 0,1,2,3,0,1 and so on.
5. Backpressure: DEPTH=4, out_deq__ENA=0, ch0 streaming -> exactly 4 pushes, count=4, then in_deq__ENA=0. A single pop -> count=3 next cycle and a push the cycle after.
6. Locked stall: ch1 owns after beat 0, drops in_first__RDY for 3 cycles while ch3 is eligible -> no ch3 push until ch1's last beat is pushed; ch3 then granted next (rr_ptr=2, ch2 idle).
